// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the seven-segment display path. Both the BCD
// formatter and the digit scanner import this package, so the 6-bit digit
// code layout is defined in exactly one place.
//   digit code: bit5 = blank, bit4 = decimal point, bits[3:0] = hex value
package sevenseg_pkg;

  typedef logic [5:0] digit_t;

  localparam int     DIG_BLANK_BIT = 5;
  localparam int     DIG_DP_BIT    = 4;
  localparam digit_t DIG_BLANK     = 6'b100000;
  localparam digit_t DIG_ERR       = 6'h0E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FORMAT
  } state_t;

  function automatic digit_t make_digit(logic blank, logic dp, logic [3:0] val);
    digit_t d;
    d = {2'b00, val};
    d[DIG_BLANK_BIT] = blank;
    d[DIG_DP_BIT]    = dp;
    return d;
  endfunction

endpackage

// File: rtl/sevenseg_bcd_fmt_if.sv
// sevenseg_bcd_fmt_if
// Request/result bundle between a measurement source and the BCD formatter.
//   start, value, dp_en, dp_pos, blank_lz : conversion request (master -> slave)
//   d0..d7                                : digit codes to the scanner, d0 rightmost
//   busy, done, ovf                       : conversion status (slave -> master)
interface sevenseg_bcd_fmt_if #(
  parameter int WIDTH = 27
);
  import sevenseg_pkg::*;

  logic             start;
  logic [WIDTH-1:0] value;
  logic             dp_en;
  logic [2:0]       dp_pos;
  logic             blank_lz;

  digit_t d0, d1, d2, d3, d4, d5, d6, d7;
  logic   busy;
  logic   done;
  logic   ovf;

  modport master (
    output start, value, dp_en, dp_pos, blank_lz,
    input  d0, d1, d2, d3, d4, d5, d6, d7, busy, done, ovf
  );

  modport slave (
    input  start, value, dp_en, dp_pos, blank_lz,
    output d0, d1, d2, d3, d4, d5, d6, d7, busy, done, ovf
  );

endinterface

// File: rtl/sevenseg_bcd_fmt_bcd_adj3.sv
// bcd_adj3
// Combinational double-dabble correction cell: adds 3 to a BCD nibble that
// is 5 or more so the following left shift carries correctly into the next
// decimal digit.
//   din  : BCD nibble before correction
//   dout : corrected nibble
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/sevenseg_bcd_fmt.sv
// sevenseg_bcd_fmt
// Converts an unsigned binary measurement into eight digit codes for the
// seven-segment scanner using an iterative shift-and-add-3 conversion, then
// applies leading-zero blanking and a decimal point. The digit outputs only
// change in the single FORMAT cycle, so the scanner never sees partial data.
//   clk : system clock
//   rst : asynchronous reset, active low
//   bus : slave side of sevenseg_bcd_fmt_if (request in, digits/status out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; outputs hold the last result
// ST_SHIFT  | one double-dabble iteration per cycle, WIDTH iterations
// ST_FORMAT | build and register all eight digit codes, pulse done
module sevenseg_bcd_fmt
  import sevenseg_pkg::*;
#(
  parameter int WIDTH = 27  // at most 27 so 99_999_999 is representable
) (
  input logic              clk,
  input logic              rst,
  sevenseg_bcd_fmt_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state_q, state_d;
  logic   accept;

  logic [WIDTH-1:0] bin_q;
  logic [31:0]      bcd_q;
  logic [31:0]      bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;

  logic       cap_dp_en;
  logic [2:0] cap_dp_pos;
  logic       cap_blank;

  digit_t dig_q [8];
  digit_t fmt   [8];
  logic   busy_q, done_q, ovf_q;

  logic [2:0] msd;
  logic [7:0] blank_v;
  logic [7:0] dp_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CW'(1)) state_d = ST_FORMAT;
      end
      ST_FORMAT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < 8; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Any 1 shifted out of the top nibble would have become a ninth decimal
  // digit, so the sticky carry is exactly "value > 99_999_999" and no
  // separate magnitude comparator is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cap_dp_en  <= 1'b0;
      cap_dp_pos <= '0;
      cap_blank  <= 1'b0;
      dig_q      <= '{default: DIG_BLANK};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bin_q      <= bus.value;
            bcd_q      <= '0;
            cnt_q      <= CW'(WIDTH);
            carry_q    <= 1'b0;
            cap_dp_en  <= bus.dp_en;
            cap_dp_pos <= bus.dp_pos;
            cap_blank  <= bus.blank_lz;
            busy_q     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bcd_q   <= {bcd_adj[30:0], bin_q[WIDTH-1]};
          bin_q   <= bin_q << 1;
          cnt_q   <= cnt_q - CW'(1);
          carry_q <= carry_q | bcd_adj[31];
        end
        ST_FORMAT: begin
          dig_q  <= fmt;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          ovf_q  <= carry_q;
        end
        default: ;
      endcase
    end
  end

  // msd stays 0 for an all-zero result, which keeps d0 showing "0".
  always_comb begin
    msd     = '0;
    blank_v = '0;
    dp_v    = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      blank_v[i] = cap_blank && (3'(i) > msd) && (i != 0) &&
                   !(cap_dp_en && (3'(i) <= cap_dp_pos));
      dp_v[i]    = cap_dp_en && (3'(i) == cap_dp_pos) && !blank_v[i];
      if (carry_q)         fmt[i] = DIG_ERR;
      else if (blank_v[i]) fmt[i] = DIG_BLANK;
      else                 fmt[i] = make_digit(1'b0, dp_v[i], bcd_q[4*i +: 4]);
    end
  end

  assign bus.d0   = dig_q[0];
  assign bus.d1   = dig_q[1];
  assign bus.d2   = dig_q[2];
  assign bus.d3   = dig_q[3];
  assign bus.d4   = dig_q[4];
  assign bus.d5   = dig_q[5];
  assign bus.d6   = dig_q[6];
  assign bus.d7   = dig_q[7];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sevenseg_bcd_fmt.sv
// tb_sevenseg_bcd_fmt
// Directed self-checking bench for sevenseg_bcd_fmt with hand-computed
// expected digit codes, latency and handshake behaviour.
module tb_sevenseg_bcd_fmt;
  import sevenseg_pkg::*;

  localparam int W   = 27;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sevenseg_bcd_fmt_if #(.WIDTH(W)) bus ();

  sevenseg_bcd_fmt #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  digit_t exp_d [8];

  function automatic digit_t dig(int i);
    case (i)
      0: return bus.d0;
      1: return bus.d1;
      2: return bus.d2;
      3: return bus.d3;
      4: return bus.d4;
      5: return bus.d5;
      6: return bus.d6;
      default: return bus.d7;
    endcase
  endfunction

  // Presents a request for exactly one rising edge; returns 1 ns after it.
  task automatic drive_start(input logic [W-1:0] v, input logic dpe,
                             input logic [2:0] dpp, input logic blz);
    bus.start    = 1'b1;
    bus.value    = v;
    bus.dp_en    = dpe;
    bus.dp_pos   = dpp;
    bus.blank_lz = blz;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Cycles from the accept edge until done is seen, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.value    = '0;
    bus.dp_en    = 1'b0;
    bus.dp_pos   = '0;
    bus.blank_lz = 1'b0;
    rst = 1'b0;
    #12;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== 6'h20) begin
        n_err++;
        $display("FAIL reset_d%0d: got %h want 20", i, dig(i));
      end
    end
    n_cmp++;
    if ({bus.busy, bus.done, bus.ovf} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_status: got busy/done/ovf %b want 000", {bus.busy, bus.done, bus.ovf});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_zero();
    int cyc;
    drive_start(27'd0, 1'b0, 3'd0, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_busy_after_accept: got %b want 1", bus.busy);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL zero_latency: got %0d want %0d", cyc, LAT);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL zero_status: got busy %b ovf %b want 0 0", bus.busy, bus.ovf);
    end
    exp_d = '{6'h00, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== exp_d[i]) begin
        n_err++;
        $display("FAIL zero_d%0d: got %h want %h", i, dig(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_digits();
    int cyc;
    drive_start(27'd12345678, 1'b0, 3'd0, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL digits_latency: got %0d want %0d", cyc, LAT);
    end
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = digit_t'(8 - i);
      n_cmp++;
      if (dig(i) !== exp_d[i]) begin
        n_err++;
        $display("FAIL digits_d%0d: got %h want %h", i, dig(i), exp_d[i]);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL digits_done_one_cycle: got %b want 0", bus.done);
    end
    n_cmp++;
    if (bus.d7 !== 6'h01 || bus.d0 !== 6'h08) begin
      n_err++;
      $display("FAIL digits_hold: got d7 %h d0 %h want 01 08", bus.d7, bus.d0);
    end
  endtask

  task automatic test_dp();
    int cyc;
    drive_start(27'd5, 1'b1, 3'd2, 1'b1);
    wait_done(cyc);
    exp_d = '{6'h05, 6'h00, 6'h10, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== exp_d[i]) begin
        n_err++;
        $display("FAIL dp_d%0d: got %h want %h", i, dig(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_max_ovf();
    int cyc;
    drive_start(27'd99_999_999, 1'b0, 3'd0, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL max_ovf: got %b want 0", bus.ovf);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== 6'h09) begin
        n_err++;
        $display("FAIL max_d%0d: got %h want 09", i, dig(i));
      end
    end
    drive_start(27'd100_000_000, 1'b1, 3'd2, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (bus.ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got %b want 1", bus.ovf);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== 6'h0E) begin
        n_err++;
        $display("FAIL ovf_d%0d: got %h want 0e", i, dig(i));
      end
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    int done_at = -1;
    drive_start(27'd4321, 1'b0, 3'd0, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n_done++;
        done_at = k;
      end
      if (k == 4 || k == 26) begin
        bus.start = 1'b1;
        bus.value = 27'd99;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_cmp++;
    if (n_done !== 1 || done_at !== LAT) begin
      n_err++;
      $display("FAIL ignore_done_count: got %0d at cycle %0d want 1 at %0d", n_done, done_at, LAT);
    end
    exp_d = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h20, 6'h20, 6'h20, 6'h20};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== exp_d[i]) begin
        n_err++;
        $display("FAIL ignore_d%0d: got %h want %h", i, dig(i), exp_d[i]);
      end
    end
    n_cmp++;
    if (bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_ovf_cleared: got %b want 0", bus.ovf);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    drive_start(27'd4321, 1'b0, 3'd0, 1'b0);
    wait_done(cyc);
    drive_start(27'd90, 1'b1, 3'd3, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept_after_done: got busy %b want 1", bus.busy);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT);
    end
    exp_d = '{6'h00, 6'h09, 6'h00, 6'h10, 6'h20, 6'h20, 6'h20, 6'h20};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== exp_d[i]) begin
        n_err++;
        $display("FAIL b2b_d%0d: got %h want %h", i, dig(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int n_done = 0;
    drive_start(27'd777, 1'b0, 3'd0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== 6'h20) begin
        n_err++;
        $display("FAIL rstmid_d%0d: got %h want 20", i, dig(i));
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_status: got busy %b done %b want 0 0", bus.busy, bus.done);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL rstmid_no_done: got %0d done pulses want 0", n_done);
    end
    drive_start(27'd1000, 1'b1, 3'd0, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL rstmid_fresh_latency: got %0d want %0d", cyc, LAT);
    end
    exp_d = '{6'h10, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dig(i) !== exp_d[i]) begin
        n_err++;
        $display("FAIL rstmid_fresh_d%0d: got %h want %h", i, dig(i), exp_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_digits();
    test_dp();
    test_max_ovf();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_bcd_fmt.md
# sevenseg_bcd_fmt

- Converts an unsigned binary measurement (heart rate, SpO2, step count, …) into eight 6-bit display digit codes.
- Uses an iterative shift-and-add-3 (double-dabble) conversion with a start/done handshake.
- Applies optional leading-zero blanking and a decimal point.
- Sits directly upstream of the eight-digit seven-segment scanner and drives its `d0`..`d7` inputs, holding them stable between conversions.

## Interface
- `WIDTH`, default 27: binary input width. Must be ≤ 27 so 99_999_999 fits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  conversion request; accepted only in IDLE.
- `value`  in  WIDTH  unsigned binary to display; sampled when `start` is accepted.
- `dp_en`  in  1  enable decimal point; sampled with `value`.
- `dp_pos`  in  3  digit index (0 = rightmost) that carries the point; sampled with `value`.
- `blank_lz`  in  1  enable leading-zero blanking; sampled with `value`.
- `d0`..`d7`  out  6 each  digit codes to the scanner; `d0` is rightmost.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle pulse in the cycle the new digits first appear.
- `ovf`  out  1  last accepted value exceeded 99_999_999.

## Operation
- Digit code format: bit5 = blank, bit4 = decimal point, bits[3:0] = hex value.
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE:
  - On `start`=1, capture `value`, `dp_en`, `dp_pos`, `blank_lz`.
  - Clear the 32-bit BCD accumulator.
  - Load the iteration counter with WIDTH and go to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every BCD nibble that is ≥ 5.
  - Shift {bcd, bin} left by 1 and decrement the counter.
  - After WIDTH iterations, go to FORMAT.
- FORMAT, single cycle:
  - Build all eight codes and register them into `d0`..`d7` simultaneously.
  - Pulse `done`, update `ovf`, return to IDLE.
- Overflow: if the captured value > 99_999_999, `ovf`=1 and every digit is value 0xE, blank 0, dp 0. Decimal point and blanking are ignored in this case.
- Blanking: with `blank_lz`=1, digit i is blanked (code 6'b100000) when all of the following hold:
  - i > index of the most-significant nonzero BCD digit;
  - i > `dp_pos` when `dp_en`=1;
  - i ≠ 0.
- `d0` is never blanked.
- Decimal point: with `dp_en`=1, bit4 is set on digit `dp_pos` only. A blanked digit never carries dp.
- Outputs hold their last FORMAT values while IDLE or SHIFT. The scanner never sees partial results.
- `start` while `busy` or in FORMAT is ignored. No queueing.

## Timing
- Reset values:
  - `d0`..`d7` = 6'b100000 (blank);
  - `busy`=0, `done`=0, `ovf`=0;
  - state IDLE; accumulator and counter 0.
- Latency, start accepted at edge N:
  - `busy`=1 from N+1;
  - FORMAT occupies cycle N+WIDTH+1;
  - new digits and `done`=1 visible after edge N+WIDTH+1, i.e. WIDTH+1 cycles after accept (28 for WIDTH=27);
  - `busy`=0 in the same cycle as `done`.
- Back-to-back: a new `start` is accepted in the cycle after `done`. Minimum period is WIDTH+2 cycles.
- Reset mid-conversion: immediate return to IDLE with outputs blank; the aborted conversion never asserts `done`.

## Structure
- Shared package `sevenseg_pkg`:
  - `digit_t` (6-bit typedef);
  - bit-position constants `DIG_BLANK_BIT`=5, `DIG_DP_BIT`=4;
  - constant `DIG_BLANK`=6'b100000;
  - constant `DIG_ERR`=6'h0E;
  - FSM state enum.
- The scanner imports the same package so both blocks share one definition of the code format.
- One sub-module: `bcd_adj3`, a combinational 4-bit "add 3 if ≥5" cell instantiated 8 times via generate.
- Everything else stays in the top module.

## Test plan
- Reset, then `value`=0, `blank_lz`=1, `dp_en`=0 → after 28 cycles `done`; `d0`=6'h00, `d1`..`d7`=6'h20, `ovf`=0.
- `value`=12345678, `blank_lz`=0 → `d7`..`d0` = 1,2,3,4,5,6,7,8; `done` exactly one cycle.
- `value`=5, `blank_lz`=1, `dp_en`=1, `dp_pos`=2 → `d2`=6'h10, `d1`=6'h00, `d0`=6'h05, `d3`..`d7`=6'h20.
- `value`=99_999_999 → all digits 6'h09, `ovf`=0. Then `value`=100_000_000 → all digits 6'h0E, `ovf`=1.
- `start` pulsed again at cycles 5 and 27 after accept → ignored; exactly one `done`; result matches the first value.
- `rst` asserted at cycle 10 of a conversion → outputs immediately 6'h20, `busy`=0, no `done`. A fresh start afterwards converts correctly.
